branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 120 ++++++++++++
 tb/tb_branch_predictor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational lookup for fetch; registered mispredict/redirect for resolved branches.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            En,
    input  logic [XLEN-1:0] Fetch_PC,
    output logic            Pred_taken,
    output logic [XLEN-1:0] Pred_target,
    input  logic            Upd_valid,
    input  logic [XLEN-1:0] Upd_PC,
    input  logic            Upd_taken,
    input  logic [XLEN-1:0] Upd_target,
    input  logic            Upd_pred_taken,
    input  logic [XLEN-1:0] Upd_pred_target,
    output logic            Mispredict,
    output logic [XLEN-1:0] Redirect_PC
);

    localparam int TAG_W = XLEN - IDX_W - 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        case (c)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            ST:      n = taken ? ST  : WT;
            default: n = c;
        endcase
        return n;
    endfunction

    logic                  valid_q [ENTRIES];
    ctr_t                  ctr_q   [ENTRIES];
    logic [TAG_W-1:0]      tag_q   [ENTRIES];
    logic [XLEN-1:0]       tgt_q   [ENTRIES];

    logic [IDX_W-1:0]      f_idx;
    logic [TAG_W-1:0]      f_tag;
    logic                  f_hit;
    logic [IDX_W-1:0]      u_idx;
    logic [TAG_W-1:0]      u_tag;
    logic                  u_hit;
    logic                  upd_en;
    logic                  mis_p0;
    logic [XLEN-1:0]       redirect_p0;

    // Stage 0: combinational lookup and update decode
    always_comb begin
        f_idx = Fetch_PC[IDX_W+1:2];
        f_tag = Fetch_PC[XLEN-1:IDX_W+2];
        u_idx = Upd_PC[IDX_W+1:2];
        u_tag = Upd_PC[XLEN-1:IDX_W+2];
        f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        upd_en = Upd_valid && En;
    end

    always_comb begin
        Pred_taken  = En && f_hit && ctr_q[f_idx][1];
        Pred_target = Pred_taken ? tgt_q[f_idx] : Fetch_PC + XLEN'(4);
    end

    always_comb begin
        mis_p0 = upd_en && ((Upd_taken != Upd_pred_taken) ||
                            (Upd_taken && (Upd_target != Upd_pred_target)));
        redirect_p0 = Upd_taken ? Upd_target : Upd_PC + XLEN'(4);
    end

    // Stage 1: table state and registered redirect
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WNT;
            end
        end else if (upd_en) begin
            if (u_hit) begin
                ctr_q[u_idx] <= ctr_step(ctr_q[u_idx], Upd_taken);
            end else if (Upd_taken) begin
                valid_q[u_idx] <= 1'b1;
                ctr_q[u_idx]   <= WT;
            end
        end
    end

    // Tag/target are qualified by valid_q, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (upd_en && Upd_taken) begin
            tag_q[u_idx] <= u_tag;
            tgt_q[u_idx] <= Upd_target;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            Mispredict  <= 1'b0;
            Redirect_PC <= '0;
        end else begin
            Mispredict <= mis_p0;
            if (upd_en) begin
                Redirect_PC <= redirect_p0;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor, with a hand-written
// asynchronous-reset sequence at the end.
module tb_branch_predictor;

    logic        CLK;
    logic        rst_n;
    logic        En;
    logic [31:0] Fetch_PC;
    logic        Pred_taken;
    logic [31:0] Pred_target;
    logic        Upd_valid;
    logic [31:0] Upd_PC;
    logic        Upd_taken;
    logic [31:0] Upd_target;
    logic        Upd_pred_taken;
    logic [31:0] Upd_pred_target;
    logic        Mispredict;
    logic [31:0] Redirect_PC;

    int n_cmp = 0;
    int n_err = 0;

    branch_predictor #(.XLEN(32), .ENTRIES(16), .IDX_W(4)) dut (
        .CLK             (CLK),
        .rst_n           (rst_n),
        .En              (En),
        .Fetch_PC        (Fetch_PC),
        .Pred_taken      (Pred_taken),
        .Pred_target     (Pred_target),
        .Upd_valid       (Upd_valid),
        .Upd_PC          (Upd_PC),
        .Upd_taken       (Upd_taken),
        .Upd_target      (Upd_target),
        .Upd_pred_taken  (Upd_pred_taken),
        .Upd_pred_target (Upd_pred_target),
        .Mispredict      (Mispredict),
        .Redirect_PC     (Redirect_PC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        en;
        logic [31:0] fpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        xpt;
        logic [31:0] xptgt;
        logic        xmis;
        logic [31:0] xrd;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic en, input logic [31:0] fpc,
                                input logic uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utgt,
                                input logic upt, input logic [31:0] uptgt,
                                input logic xpt, input logic [31:0] xptgt,
                                input logic xmis, input logic [31:0] xrd);
        vec_t v;
        v.en = en;   v.fpc = fpc;   v.uv = uv;     v.upc = upc;
        v.ut = ut;   v.utgt = utgt; v.upt = upt;   v.uptgt = uptgt;
        v.xpt = xpt; v.xptgt = xptgt; v.xmis = xmis; v.xrd = xrd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic drive_upd(input logic uv, input logic [31:0] upc, input logic ut,
                             input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt);
        Upd_valid       = uv;
        Upd_PC          = upc;
        Upd_taken       = ut;
        Upd_target      = utgt;
        Upd_pred_taken  = upt;
        Upd_pred_target = uptgt;
    endtask

    initial begin
        //            en fetch         uv upc           ut utgt     upt uptgt        xpt xptgt          xmis xrd
        vecs[0]  = mk(1, 32'h100,      0, 32'h0,        0, 32'h0,   0, 32'h0,        0, 32'h104,        0, 32'h0);
        vecs[1]  = mk(1, 32'h100,      1, 32'h100,      1, 32'h80,  0, 32'h0,        0, 32'h104,        1, 32'h80);
        vecs[2]  = mk(1, 32'h100,      0, 32'h0,        0, 32'h0,   0, 32'h0,        1, 32'h80,         0, 32'h80);
        vecs[3]  = mk(1, 32'h100,      1, 32'h100,      1, 32'h80,  1, 32'h80,       1, 32'h80,         0, 32'h80);
        vecs[4]  = mk(1, 32'h100,      1, 32'h100,      1, 32'h80,  1, 32'h80,       1, 32'h80,         0, 32'h80);
        vecs[5]  = mk(1, 32'h100,      1, 32'h100,      0, 32'h0,   1, 32'h80,       1, 32'h80,         1, 32'h104);
        vecs[6]  = mk(1, 32'h100,      0, 32'h0,        0, 32'h0,   0, 32'h0,        1, 32'h80,         0, 32'h104);
        vecs[7]  = mk(1, 32'h100,      1, 32'h100,      0, 32'h0,   1, 32'h80,       1, 32'h80,         1, 32'h104);
        vecs[8]  = mk(1, 32'h100,      0, 32'h0,        0, 32'h0,   0, 32'h0,        0, 32'h104,        0, 32'h104);
        vecs[9]  = mk(1, 32'h100,      1, 32'h100,      1, 32'h90,  1, 32'h80,       0, 32'h104,        1, 32'h90);
        vecs[10] = mk(1, 32'h100,      0, 32'h0,        0, 32'h0,   0, 32'h0,        1, 32'h90,         0, 32'h90);
        vecs[11] = mk(1, 32'h140,      0, 32'h0,        0, 32'h0,   0, 32'h0,        0, 32'h144,        0, 32'h90);
        vecs[12] = mk(1, 32'h100,      1, 32'h140,      1, 32'h200, 0, 32'h144,      1, 32'h90,         1, 32'h200);
        vecs[13] = mk(1, 32'h100,      0, 32'h0,        0, 32'h0,   0, 32'h0,        0, 32'h104,        0, 32'h200);
        vecs[14] = mk(1, 32'h140,      0, 32'h0,        0, 32'h0,   0, 32'h0,        1, 32'h200,        0, 32'h200);
        vecs[15] = mk(1, 32'h104,      1, 32'h104,      0, 32'h0,   0, 32'h108,      0, 32'h108,        0, 32'h108);
        vecs[16] = mk(1, 32'h104,      0, 32'h0,        0, 32'h0,   0, 32'h0,        0, 32'h108,        0, 32'h108);
        vecs[17] = mk(1, 32'h142,      0, 32'h0,        0, 32'h0,   0, 32'h0,        1, 32'h200,        0, 32'h108);
        vecs[18] = mk(0, 32'h140,      1, 32'h140,      0, 32'h0,   1, 32'h200,      0, 32'h144,        0, 32'h108);
        vecs[19] = mk(1, 32'h140,      0, 32'h0,        0, 32'h0,   0, 32'h0,        1, 32'h200,        0, 32'h108);
        vecs[20] = mk(1, 32'hFFFFFFFC, 0, 32'h0,        0, 32'h0,   0, 32'h0,        0, 32'h0,          0, 32'h108);
        vecs[21] = mk(1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 32'h40,  1, 32'h40,       0, 32'h0,          0, 32'h40);
        vecs[22] = mk(1, 32'hFFFFFFFC, 0, 32'h0,        0, 32'h0,   0, 32'h0,        1, 32'h40,         0, 32'h40);

        rst_n    = 1'b0;
        En       = 1'b1;
        Fetch_PC = 32'h100;
        drive_upd(0, 32'h0, 0, 32'h0, 0, 32'h0);
        #2;
        chk("reset_mispredict", {31'b0, Mispredict}, 32'h0);
        chk("reset_redirect", Redirect_PC, 32'h0);
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge CLK);
            En       = vecs[i].en;
            Fetch_PC = vecs[i].fpc;
            drive_upd(vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt,
                      vecs[i].upt, vecs[i].uptgt);
            #1;
            chk($sformatf("v%0d_pred_taken", i), {31'b0, Pred_taken}, {31'b0, vecs[i].xpt});
            chk($sformatf("v%0d_pred_target", i), Pred_target, vecs[i].xptgt);
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d_mispredict", i), {31'b0, Mispredict}, {31'b0, vecs[i].xmis});
            chk($sformatf("v%0d_redirect", i), Redirect_PC, vecs[i].xrd);
        end

        // Asynchronous reset between edges after training.
        @(negedge CLK);
        En       = 1'b1;
        Fetch_PC = 32'h140;
        drive_upd(1, 32'h140, 1, 32'h300, 0, 32'h200);
        @(posedge CLK);
        #1;
        chk("pre_rst_mispredict", {31'b0, Mispredict}, 32'h1);
        chk("pre_rst_redirect", Redirect_PC, 32'h300);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_mispredict", {31'b0, Mispredict}, 32'h0);
        chk("async_rst_redirect", Redirect_PC, 32'h0);
        chk("async_rst_pred_taken", {31'b0, Pred_taken}, 32'h0);
        chk("async_rst_pred_target", Pred_target, 32'h144);
        drive_upd(1, 32'h100, 1, 32'h80, 0, 32'h0);
        Fetch_PC = 32'h100;
        @(posedge CLK);
        #1;
        chk("rst_edge_mispredict", {31'b0, Mispredict}, 32'h0);
        chk("rst_edge_redirect", Redirect_PC, 32'h0);
        chk("rst_edge_pred_taken", {31'b0, Pred_taken}, 32'h0);
        @(negedge CLK);
        rst_n = 1'b1;
        drive_upd(0, 32'h0, 0, 32'h0, 0, 32'h0);
        #1;
        chk("post_rst_pred_taken", {31'b0, Pred_taken}, 32'h0);
        chk("post_rst_pred_target", Pred_target, 32'h104);
        @(negedge CLK);
        drive_upd(1, 32'h100, 1, 32'h80, 0, 32'h0);
        @(posedge CLK);
        #1;
        chk("resume_mispredict", {31'b0, Mispredict}, 32'h1);
        chk("resume_redirect", Redirect_PC, 32'h80);
        chk("resume_pred_taken", {31'b0, Pred_taken}, 32'h1);
        chk("resume_pred_target", Pred_target, 32'h80);
        @(negedge CLK);
        drive_upd(0, 32'h0, 0, 32'h0, 0, 32'h0);
        @(posedge CLK);
        #1;
        chk("pulse_end_mispredict", {31'b0, Mispredict}, 32'h0);
        chk("hold_redirect", Redirect_PC, 32'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
